// File: rtl/apb_master_pkg.sv
// Shared types for the APB initiator: FSM states, response codes and
// the timeout counter width rule.
package apb_master_pkg;

   typedef enum logic [1:0] {
      IDLE,
      SETUP,
      ACCESS,
      RESP
   } apb_mst_state_e;

   typedef enum logic [1:0] {
      RSP_OK       = 2'd0,
      RSP_SLVERR   = 2'd1,
      RSP_TIMEOUT  = 2'd2,
      RSP_MISALIGN = 2'd3
   } apb_rsp_e;

   // Wide enough to hold the timeout limit; never narrower than one bit.
   function automatic int unsigned cnt_width(input int unsigned timeout);
      return (timeout == 0) ? 1 : $clog2(timeout + 1);
   endfunction

endpackage

// File: rtl/apb_master.sv
// APB3 initiator: converts a valid/ready request into one SETUP/ACCESS
// transfer and returns a held response with a status code.
module apb_master
   import apb_master_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH     = 32,
   parameter int unsigned DATA_WIDTH     = 32,
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic                  clk,
   input  logic                  rstn_i,
   input  logic                  req_valid_i,
   output logic                  req_ready_o,
   input  logic [ADDR_WIDTH-1:0] req_addr_i,
   input  logic                  req_write_i,
   input  logic [DATA_WIDTH-1:0] req_wdata_i,
   output logic                  rsp_valid_o,
   input  logic                  rsp_ready_i,
   output logic [DATA_WIDTH-1:0] rsp_rdata_o,
   output logic [1:0]            rsp_code_o,
   output logic [ADDR_WIDTH-1:0] PADDR,
   output logic                  PSEL,
   output logic                  PENABLE,
   output logic                  PWRITE,
   output logic [DATA_WIDTH-1:0] PWDATA,
   input  logic [DATA_WIDTH-1:0] PRDATA,
   input  logic                  PREADY,
   input  logic                  PSLVERR
);

   localparam int unsigned   CW        = cnt_width(TIMEOUT_CYCLES);
   localparam int unsigned   TO_LAST_I = (TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1;
   localparam logic [CW-1:0] TO_LAST   = CW'(TO_LAST_I);

   apb_mst_state_e        state_q, state_d;
   logic [ADDR_WIDTH-1:0] paddr_q;
   logic [DATA_WIDTH-1:0] pwdata_q;
   logic                  pwrite_q;
   logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
   apb_rsp_e              code_q, code_d;
   logic [CW-1:0]         cnt_q, cnt_d;
   logic                  load_bus;

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      rdata_d  = rdata_q;
      code_d   = code_q;
      load_bus = 1'b0;
      unique case (state_q)
         IDLE: begin
            cnt_d = '0;
            if (req_valid_i) begin
               if (req_addr_i[1:0] != 2'b00) begin
                  state_d = RESP;
                  code_d  = RSP_MISALIGN;
                  rdata_d = '0;
               end else begin
                  state_d  = SETUP;
                  load_bus = 1'b1;
               end
            end
         end
         SETUP: state_d = ACCESS;
         ACCESS: begin
            // PREADY is tested first so it wins over a simultaneous timeout.
            if (PREADY) begin
               state_d = RESP;
               cnt_d   = '0;
               code_d  = PSLVERR ? RSP_SLVERR : RSP_OK;
               rdata_d = pwrite_q ? '0 : PRDATA;
            end else if ((TIMEOUT_CYCLES != 0) && (cnt_q == TO_LAST)) begin
               state_d = RESP;
               cnt_d   = '0;
               code_d  = RSP_TIMEOUT;
               rdata_d = '0;
            end else if (cnt_q != '1) begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         RESP: begin
            if (rsp_ready_i) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rstn_i) begin
         state_q  <= IDLE;
         paddr_q  <= '0;
         pwdata_q <= '0;
         pwrite_q <= 1'b0;
         rdata_q  <= '0;
         code_q   <= RSP_OK;
         cnt_q    <= '0;
      end else begin
         state_q <= state_d;
         rdata_q <= rdata_d;
         code_q  <= code_d;
         cnt_q   <= cnt_d;
         // Bus fields load only for aligned requests so they stay quiet otherwise.
         if (load_bus) begin
            paddr_q  <= req_addr_i;
            pwdata_q <= req_wdata_i;
            pwrite_q <= req_write_i;
         end
      end
   end

   assign req_ready_o = (state_q == IDLE);
   assign rsp_valid_o = (state_q == RESP);
   assign rsp_rdata_o = rdata_q;
   assign rsp_code_o  = code_q;
   assign PSEL        = (state_q == SETUP) || (state_q == ACCESS);
   assign PENABLE     = (state_q == ACCESS);
   assign PADDR       = paddr_q;
   assign PWDATA      = pwdata_q;
   assign PWRITE      = pwrite_q;

endmodule

// File: tb/tb_apb_master.sv
// Directed bench for apb_master with TIMEOUT_CYCLES=8 and a scripted APB slave.
module tb_apb_master;

   logic        clk = 1'b0;
   logic        rstn_i;
   logic        req_valid_i;
   logic        req_ready_o;
   logic [31:0] req_addr_i;
   logic        req_write_i;
   logic [31:0] req_wdata_i;
   logic        rsp_valid_o;
   logic        rsp_ready_i;
   logic [31:0] rsp_rdata_o;
   logic [1:0]  rsp_code_o;
   logic [31:0] PADDR;
   logic        PSEL;
   logic        PENABLE;
   logic        PWRITE;
   logic [31:0] PWDATA;
   logic [31:0] PRDATA;
   logic        PREADY;
   logic        PSLVERR;

   int checks   = 0;
   int failures = 0;
   int acc;

   always #5 clk = ~clk;

   apb_master #(
      .ADDR_WIDTH    (32),
      .DATA_WIDTH    (32),
      .TIMEOUT_CYCLES(8)
   ) dut (
      .clk        (clk),
      .rstn_i     (rstn_i),
      .req_valid_i(req_valid_i),
      .req_ready_o(req_ready_o),
      .req_addr_i (req_addr_i),
      .req_write_i(req_write_i),
      .req_wdata_i(req_wdata_i),
      .rsp_valid_o(rsp_valid_o),
      .rsp_ready_i(rsp_ready_i),
      .rsp_rdata_o(rsp_rdata_o),
      .rsp_code_o (rsp_code_o),
      .PADDR      (PADDR),
      .PSEL       (PSEL),
      .PENABLE    (PENABLE),
      .PWRITE     (PWRITE),
      .PWDATA     (PWDATA),
      .PRDATA     (PRDATA),
      .PREADY     (PREADY),
      .PSLVERR    (PSLVERR)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Presents one request at a negedge; returns at the first negedge after the accept edge.
   task automatic do_req(input logic [31:0] addr, input logic write, input logic [31:0] wdata);
      check("req_ready_before_req", req_ready_o, 1);
      req_valid_i = 1'b1;
      req_addr_i  = addr;
      req_write_i = write;
      req_wdata_i = wdata;
      @(negedge clk);
      req_valid_i = 1'b0;
   endtask

   // Called in SETUP; PREADY rises in ACCESS cycle waits+1. Returns at the first
   // negedge with PENABLE low, acc = ACCESS cycles seen (bounded at 20).
   task automatic run_access(input int waits, output int n);
      n = 0;
      for (int k = 1; k <= 20; k++) begin
         @(negedge clk);
         if (!PENABLE) break;
         n++;
         PREADY = (k > waits);
      end
      PREADY = 1'b0;
   endtask

   initial begin
      rstn_i      = 1'b0;
      req_valid_i = 1'b0;
      req_addr_i  = '0;
      req_write_i = 1'b0;
      req_wdata_i = '0;
      rsp_ready_i = 1'b1;
      PRDATA      = '0;
      PREADY      = 1'b0;
      PSLVERR     = 1'b0;
      repeat (2) @(negedge clk);

      check("rst_psel", PSEL, 0);
      check("rst_penable", PENABLE, 0);
      check("rst_pwrite", PWRITE, 0);
      check("rst_paddr", PADDR, 0);
      check("rst_pwdata", PWDATA, 0);
      check("rst_rsp_valid", rsp_valid_o, 0);
      check("rst_rdata", rsp_rdata_o, 0);
      check("rst_code", rsp_code_o, 0);
      rstn_i = 1'b1;
      @(negedge clk);

      // Zero-wait write 0x41 to 0x0: SETUP N+1, ACCESS N+2, response N+3
      PREADY = 1'b1;
      do_req(32'h0, 1'b1, 32'h41);
      check("w_setup_psel", PSEL, 1);
      check("w_setup_penable", PENABLE, 0);
      check("w_setup_pwdata", PWDATA, 32'h41);
      check("w_setup_paddr", PADDR, 32'h0);
      check("w_setup_pwrite", PWRITE, 1);
      check("w_setup_req_ready", req_ready_o, 0);
      @(negedge clk);
      check("w_access_psel", PSEL, 1);
      check("w_access_penable", PENABLE, 1);
      check("w_access_pwdata", PWDATA, 32'h41);
      @(negedge clk);
      PREADY = 1'b0;
      check("w_rsp_valid", rsp_valid_o, 1);
      check("w_rsp_code", rsp_code_o, 0);
      check("w_rsp_rdata", rsp_rdata_o, 0);
      check("w_rsp_psel", PSEL, 0);
      @(negedge clk);
      check("w_idle_rsp_valid", rsp_valid_o, 0);

      // Read 0x4 with 3 wait states
      PRDATA = 32'hA5;
      do_req(32'h4, 1'b0, 32'h0);
      check("r_setup_paddr", PADDR, 32'h4);
      check("r_setup_pwrite", PWRITE, 0);
      run_access(3, acc);
      check("r_access_cycles", acc, 4);
      check("r_rsp_valid", rsp_valid_o, 1);
      check("r_rsp_rdata", rsp_rdata_o, 32'hA5);
      check("r_rsp_code", rsp_code_o, 0);
      @(negedge clk);

      // Write 0x14 with PSLVERR: rdata forced to 0
      PSLVERR = 1'b1;
      PRDATA  = 32'hDEAD;
      do_req(32'h14, 1'b1, 32'h5A5A);
      run_access(0, acc);
      check("we_access_cycles", acc, 1);
      check("we_rsp_code", rsp_code_o, 1);
      check("we_rsp_rdata", rsp_rdata_o, 0);
      @(negedge clk);
      check("we_after_psel", PSEL, 0);
      check("we_after_req_ready", req_ready_o, 1);

      // Read 0x8 with PSLVERR: sampled PRDATA returned
      PRDATA = 32'h1234;
      do_req(32'h8, 1'b0, 32'h0);
      run_access(0, acc);
      PSLVERR = 1'b0;
      check("re_rsp_code", rsp_code_o, 1);
      check("re_rsp_rdata", rsp_rdata_o, 32'h1234);
      @(negedge clk);

      // Slave never ready: timeout after exactly 8 ACCESS cycles
      PRDATA = 32'hBEEF;
      do_req(32'h20, 1'b0, 32'h0);
      run_access(100, acc);
      check("to_access_cycles", acc, 8);
      check("to_rsp_valid", rsp_valid_o, 1);
      check("to_rsp_code", rsp_code_o, 2);
      check("to_rsp_rdata", rsp_rdata_o, 0);
      check("to_psel", PSEL, 0);
      @(negedge clk);

      // PREADY arriving in the last allowed cycle beats the timeout
      PRDATA = 32'h77;
      do_req(32'h24, 1'b0, 32'h0);
      run_access(7, acc);
      check("race_access_cycles", acc, 8);
      check("race_rsp_code", rsp_code_o, 0);
      check("race_rsp_rdata", rsp_rdata_o, 32'h77);
      @(negedge clk);

      // Misaligned 0x6: response one cycle after accept, bus untouched
      do_req(32'h6, 1'b1, 32'hFFFF);
      check("mis_rsp_valid", rsp_valid_o, 1);
      check("mis_rsp_code", rsp_code_o, 3);
      check("mis_rsp_rdata", rsp_rdata_o, 0);
      check("mis_psel", PSEL, 0);
      check("mis_paddr_held", PADDR, 32'h24);
      check("mis_pwrite_held", PWRITE, 0);
      @(negedge clk);
      check("mis_after_psel", PSEL, 0);

      // Response held while rsp_ready_i low
      rsp_ready_i = 1'b0;
      PRDATA = 32'hCAFE;
      do_req(32'h30, 1'b0, 32'h0);
      run_access(0, acc);
      for (int i = 0; i < 5; i++) begin
         check("hold_rsp_valid", rsp_valid_o, 1);
         check("hold_rsp_rdata", rsp_rdata_o, 32'hCAFE);
         check("hold_rsp_code", rsp_code_o, 0);
         PRDATA = 32'(i);
         @(negedge clk);
      end
      check("hold_req_ready", req_ready_o, 0);
      rsp_ready_i = 1'b1;
      @(negedge clk);
      check("hold_release_rsp_valid", rsp_valid_o, 0);

      // Reset during ACCESS aborts the transfer
      do_req(32'h40, 1'b1, 32'h99);
      @(negedge clk);
      check("abort_penable", PENABLE, 1);
      rstn_i = 1'b0;
      @(negedge clk);
      check("abort_psel", PSEL, 0);
      check("abort_penable_low", PENABLE, 0);
      check("abort_pwrite", PWRITE, 0);
      check("abort_paddr", PADDR, 0);
      check("abort_pwdata", PWDATA, 0);
      check("abort_rsp_valid", rsp_valid_o, 0);
      check("abort_rdata", rsp_rdata_o, 0);
      check("abort_code", rsp_code_o, 0);
      rstn_i = 1'b1;
      @(negedge clk);
      check("abort_after_rsp_valid", rsp_valid_o, 0);
      check("abort_after_psel", PSEL, 0);
      check("abort_after_req_ready", req_ready_o, 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
